// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer, registered grants
// and a mandatory one-cycle dead gap between owners. Define RING_ARB_TIMEOUT_EN to
// revoke grants held for MAX_HOLD cycles.
module ring_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [N-1:0]     Req,
  output logic [N-1:0]     Grant,
  output logic [IDX_W-1:0] Grant_idx,
  output logic             Busy,
  output logic             Timeout
);

  if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_bad_param
    $error("ring_arbiter: N must be 2..8 and MAX_HOLD at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     ptr;
  logic [IDX_W-1:0] ptr_idx_c;
  logic             win_valid_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [N-1:0]     win_onehot_c;
  logic             owner_req_c;
  logic             hold_expired_c;

  // Index reached by stepping 'off' places upward from 'base', wrapping at N.
  function automatic logic [IDX_W-1:0] ring_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    return IDX_W'((32'(base) + off) % N);
  endfunction

  always_comb begin
    ptr_idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr[i]) ptr_idx_c = IDX_W'(i);
    end
  end

  // First requester at or above the pointer, wrapping, wins.
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!win_valid_c && Req[ring_idx(ptr_idx_c, k)]) begin
        win_valid_c = 1'b1;
        win_idx_c   = ring_idx(ptr_idx_c, k);
      end
    end
  end

  assign win_onehot_c = N'(1) << win_idx_c;
  assign owner_req_c  = |(Req & Grant);

`ifdef RING_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;

  assign hold_expired_c = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign hold_expired_c = 1'b0;
  assign Timeout        = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      ptr       <= N'(1);
      Grant     <= '0;
      Grant_idx <= '0;
      Busy      <= 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
      Timeout   <= 1'b0;
      hold_cnt  <= '0;
`endif
    end else begin
`ifdef RING_ARB_TIMEOUT_EN
      Timeout <= 1'b0;
`endif
      case (state)
        IDLE, GAP: begin
          if (win_valid_c) begin
            state     <= GRANTED;
            Grant     <= win_onehot_c;
            Grant_idx <= win_idx_c;
            Busy      <= 1'b1;
`ifdef RING_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANTED: begin
          // Release or forced revoke: owner moves to lowest priority.
          if (!owner_req_c || hold_expired_c) begin
            state     <= GAP;
            Grant     <= '0;
            Grant_idx <= '0;
            Busy      <= 1'b0;
            ptr       <= {Grant[N-2:0], Grant[N-1]};
`ifdef RING_ARB_TIMEOUT_EN
            Timeout   <= owner_req_c;
`endif
          end else begin
`ifdef RING_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
          end
        end
        default: begin
          state     <= IDLE;
          Grant     <= '0;
          Grant_idx <= '0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_arbiter.sv
// Self-checking bench for ring_arbiter: directed scenarios plus random request
// traffic, compared every cycle against an owner/pointer reference model.
module tb_ring_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned IDX_W    = 2;

  logic             Clock;
  logic             Reset_n;
  logic [N-1:0]     Req;
  logic [N-1:0]     Grant;
  logic [IDX_W-1:0] Grant_idx;
  logic             Busy;
  logic             Timeout;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference model: current owner (-1 = none), priority index, cycles granted so far.
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_to;

  ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDX_W(IDX_W)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Req      (Req),
    .Grant    (Grant),
    .Grant_idx(Grant_idx),
    .Busy     (Busy),
    .Timeout  (Timeout)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  // One rising edge of the reference, given the request vector sampled at it.
  function automatic void model_step(input logic [N-1:0] r);
    bit own;
    bit expire;
    bit found;
    int idx;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      own    = ((r >> m_owner) & 1) != 0;
      expire = 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
      expire = (m_held >= int'(MAX_HOLD));
`endif
      if (!own || expire) begin
        m_to    = own && expire;
        m_ptr   = (m_owner + 1) % int'(N);
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        idx = (m_ptr + k) % int'(N);
        if (!found && (((r >> idx) & 1) != 0)) begin
          found   = 1'b1;
          m_owner = idx;
          m_held  = 1;
        end
      end
    end
  endfunction

  task automatic check_all();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check_eq("grant",     32'(Grant),     32'(eg));
    check_eq("grant_idx", 32'(Grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_eq("busy",      32'(Busy),      32'(m_owner >= 0));
    check_eq("timeout",   32'(Timeout),   32'(m_to));
  endtask

  // Called at a falling edge: drive r, advance one rising edge, check at next falling edge.
  task automatic cycle(input logic [N-1:0] r);
    Req = r;
    model_step(r);
    @(negedge Clock);
    check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_grant", 32'(Grant), 32'd0);
    check_eq("rst_busy",  32'(Busy),  32'd0);
    check_all();
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    Reset_n = 1'b0;
    Req     = '0;
    model_reset();
    repeat (3) @(negedge Clock);
    check_all();
    Reset_n = 1'b1;

    // All requesting from reset: strict rotation with one-cycle gaps.
    for (int g = 0; g < 5; g++) begin
      cycle(4'b1111);
      check_eq("rr_order", 32'(Grant), 32'(N'(1) << (g % 4)));
      cycle(4'b1111);
      cycle(4'b1111);
      cycle(4'b1111 & ~(N'(1) << (g % 4)));
      check_eq("rr_gap", 32'(Grant), 32'd0);
    end

    // Late request from requester 0 ignored while 2 holds.
    do_reset();
    cycle(4'b0100);
    for (int c = 1; c < 10; c++) begin
      cycle((c >= 3) ? 4'b0101 : 4'b0100);
      check_eq("late_hold", 32'(Grant), 32'h4);
    end
    cycle(4'b0001);
    check_eq("late_gap", 32'(Grant), 32'd0);
    cycle(4'b0001);
    check_eq("late_next", 32'(Grant), 32'h1);

    // Skip to next requester, then handover after the gap.
    do_reset();
    cycle(4'b1010);
    check_eq("skip_grant", 32'(Grant), 32'h2);
    check_eq("skip_idx",   32'(Grant_idx), 32'd1);
    cycle(4'b1000);
    cycle(4'b1000);
    check_eq("skip_next", 32'(Grant), 32'h8);

    // Single-cycle request, return to idle, requester 0 still granted alone.
    do_reset();
    cycle(4'b0001);
    cycle(4'b0000);
    cycle(4'b0000);
    check_eq("idle_busy", 32'(Busy), 32'd0);
    cycle(4'b0001);
    check_eq("idle_regrant", 32'(Grant), 32'h1);

    // Reset mid-grant, then first grant on the first edge after release.
    cycle(4'b0100);
    cycle(4'b0100);
    do_reset();
    cycle(4'b0001);
    check_eq("post_rst", 32'(Grant), 32'h1);

    // Continuous 0011: timeout alternation, or indefinite hold without the feature.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cycle(4'b0011);
`ifdef RING_ARB_TIMEOUT_EN
      if (i <= 16) check_eq("to_own0", 32'(Grant), 32'h1);
      if (i == 17) check_eq("to_pulse", 32'(Timeout), 32'd1);
      if (i >= 18 && i <= 33) check_eq("to_own1", 32'(Grant), 32'h2);
`else
      check_eq("hold_own0", 32'(Grant), 32'h1);
      check_eq("hold_noto", 32'(Timeout), 32'd0);
`endif
    end

    // Random sticky requests with occasional asynchronous resets.
    do_reset();
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < int'(N); b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      cycle(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter that shares one resource among N requesters, such as a shared ring-counter register or shift datapath. A one-hot priority pointer rotates like a ring counter, so each requester is guaranteed a turn. Grants are registered, held while the owner keeps its request high, and separated by a mandatory one-cycle dead gap so the shared resource never has two drivers. The block sits between the requesting engines and the shared resource's enable/select inputs.

## Interface
- N, 4, number of requesters (2..8)
- MAX_HOLD, 16, maximum consecutive GRANTED cycles per grant; used only when the timeout feature is compiled in
- IDX_W, $clog2(N), width of Grant_idx; derived, not overridden
- Clock  input  1  single clock; all state updates on the rising edge
- Reset_n  input  1  reset, asynchronous and active-low
- Req  input  N  per-requester request; held high for as long as the resource is needed
- Grant  output  N  one-hot grant, registered; all-zero when idle or in the gap
- Grant_idx  output  IDX_W  binary index of the current owner; 0 when Grant is zero
- Busy  output  1  high while any Grant bit is high
- Timeout  output  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- State machine: IDLE, GRANTED, GAP.
- Priority pointer Ptr: N-bit one-hot. The highest-priority requester is the bit Ptr points to; priority then descends upward through the indices, wrapping from N-1 to 0.
- Arbitration is combinational over Req and Ptr; its result is registered into Grant.
- IDLE:
  - If any Req bit is high, go to GRANTED, load Grant with the winner and set Grant_idx to match.
  - Otherwise stay in IDLE.
- GRANTED:
  - While Req[Grant_idx] is high, hold Grant unchanged. Other requests are ignored.
  - When Req[Grant_idx] is low: go to GAP, clear Grant to 0, and set Ptr to the grant rotated left by 1, wrapping bit N-1 to bit 0.
- GAP:
  - Grant stays 0 for exactly one cycle.
  - Then arbitrate as in IDLE: go to GRANTED if any request is pending, otherwise go to IDLE.
- Requests that drop before being granted are simply not considered; no request is latched.
- A requester that is re-requesting gets the lowest priority immediately after its own grant ends.
- Reset (async, Reset_n = 0):
  - Outputs: Grant = 0, Grant_idx = 0, Busy = 0, Timeout = 0.
  - Internal: state = IDLE, Ptr = 0...01.
  - Reset takes effect mid-grant with no GAP cycle.
- Ptr is always exactly one-hot, both out of reset and after every update.

## Timing
- Request to grant: Req sampled high at edge k gives Grant valid after edge k (1-cycle latency from an idle state).
- Release: Req[owner] sampled low at edge k drops Grant after edge k. The next grant appears after edge k+1 at the earliest, so there is a minimum one-cycle dead gap.
- Back-to-back throughput: one handover per (hold cycles + 1).
- Simultaneous requests in IDLE: the requester nearest Ptr wins; ties are impossible.
- Owner drop and other requests in the same cycle: GAP still occurs; the pointer has already advanced before arbitration.
- Busy = |Grant. It is registered consistently with Grant (no combinational path from Req).
- Reset release: the first grant is possible on the first rising edge after Reset_n deasserts.

## Configuration
- RING_ARB_TIMEOUT_EN defined:
  - A hold counter clears on entry to GRANTED and increments each GRANTED cycle.
  - When the counter reaches MAX_HOLD and Req[owner] is still high, the block goes to GAP, pulses Timeout for one cycle (aligned with Grant dropping) and rotates Ptr past the owner as for a normal release.
  - The preempted requester stays eligible but now has the lowest priority.
- RING_ARB_TIMEOUT_EN undefined:
  - No counter is built and Timeout is tied to 0.
  - Grants are held indefinitely while Req[owner] stays high.

## Test plan
- Reset mid-grant:
  - Stimulus: Req=0100 granted, then Reset_n pulsed low asynchronously between edges.
  - Response: Grant=0000, Busy=0 immediately.
  - After release with Req=0001: Grant=0001 one edge later.
- Simultaneous requests after reset:
  - Stimulus: Req=1111 from reset, each owner holding for 3 cycles then dropping for 1 cycle.
  - Response: grant order 0001, 0010, 0100, 1000, 0001, with Grant=0 for exactly one cycle between each.
- Skip to next requester:
  - Stimulus: Req=1010 with Ptr=0001.
  - Response: Grant=0010, Grant_idx=1. After release, with Req=1000 still held: Grant=1000 two edges after the drop.
- Late request ignored during a grant:
  - Stimulus: owner 2 holds for 10 cycles; requester 0 asserts during cycle 3.
  - Response: Grant stays 0100 throughout.
  - After release: Grant=0001 following the one-cycle gap.
- Timeout (RING_ARB_TIMEOUT_EN, MAX_HOLD=16):
  - Stimulus: Req=0011 held high continuously.
  - Response: Grant=0001 for 16 cycles, then Timeout=1 for one cycle with Grant=0, then Grant=0010 for 16 cycles, alternating.
  - With the macro undefined: Grant=0001 forever and Timeout=0.
- Idle return:
  - Stimulus: single Req=0001 pulse lasting 1 cycle.
  - Response: Grant=0001 for 1 cycle, then GAP, then IDLE with Grant=0 and Busy=0.
  - Next request from requester 0: Ptr=0010, so requester 0 is still granted when it is the only requester.
